// File: rtl/extender_pkg.sv
// Shared constants for the immediate extender and the branch-offset path that
// reuses its core.
package extender_pkg;

   localparam int unsigned IMM_W  = 16;
   localparam int unsigned WORD_W = 32;

   localparam logic EXT_ZERO = 1'b0;
   localparam logic EXT_SIGN = 1'b1;

endpackage

// File: rtl/extender_if.sv
// Immediate/result bundle between the decode stage (master) and the extender (slave).
interface extender_if #(
   parameter int unsigned IN_W  = extender_pkg::IMM_W,
   parameter int unsigned OUT_W = extender_pkg::WORD_W
) ();

   logic [IN_W-1:0]  a;
   logic             sel;
   logic             en;
   logic [OUT_W-1:0] z;
   logic [OUT_W-1:0] z_q;
   logic             valid_q;

   modport master (
      output a, sel, en,
      input  z, z_q, valid_q
   );

   modport slave (
      input  a, sel, en,
      output z, z_q, valid_q
   );

endinterface

// File: rtl/extend_core.sv
// Purely combinational sign/zero widening of an immediate; OUT_W must exceed IN_W.
module extend_core
   import extender_pkg::*;
#(
   parameter int unsigned IN_W  = IMM_W,
   parameter int unsigned OUT_W = WORD_W
) (
   input  logic [IN_W-1:0]  a,
   input  logic             sel,
   output logic [OUT_W-1:0] z
);

   logic fill;

   always_comb begin
      fill = (sel == EXT_SIGN) ? a[IN_W-1] : EXT_ZERO;
      z    = {{(OUT_W - IN_W){fill}}, a};
   end

endmodule

// File: rtl/extender.sv
// Immediate extender top: combinational result plus an en-strobed capture register
// with a valid flag for pipelined/debug consumers.
module extender
   import extender_pkg::*;
#(
   parameter int unsigned IN_W  = IMM_W,
   parameter int unsigned OUT_W = WORD_W
) (
   input  logic       clk,
   input  logic       rst_n,
   extender_if.slave  bus
);

   logic [OUT_W-1:0] z;
   logic [OUT_W-1:0] cap_d, cap_q;
   logic             vld_d, vld_q;

   extend_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_core (
      .a   (bus.a),
      .sel (bus.sel),
      .z   (z)
   );

   always_comb begin
      cap_d = cap_q;
      vld_d = vld_q;
      if (bus.en) begin
         cap_d = z;
         vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_q <= '0;
         vld_q <= 1'b0;
      end else begin
         cap_q <= cap_d;
         vld_q <= vld_d;
      end
   end

   assign bus.z       = z;
   assign bus.z_q     = cap_q;
   assign bus.valid_q = vld_q;

endmodule

// File: tb/tb_extender.sv
// Self-checking bench for extender: constant vectors, a reference model and a
// scoreboard of expected registered outputs.
module tb_extender;

   logic clk = 1'b0;
   logic rst_n;

   int n_tests = 0;
   int n_fail  = 0;

   logic [32:0] exp_q[$];

   extender_if bus ();

   extender dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #10 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] model(input logic [15:0] a, input logic s);
      logic [15:0] hi;
      hi = (s && a[15]) ? 16'hFFFF : 16'h0000;
      return {hi, a};
   endfunction

   task automatic check_reg(input string name);
      logic [32:0] e;
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         e = exp_q.pop_front();
         if ({bus.valid_q, bus.z_q} !== e) begin
            n_fail++;
            $display("FAIL %s: got valid=%b z_q=%h, expected valid=%b z_q=%h",
                     name, bus.valid_q, bus.z_q, e[32], e[31:0]);
         end
      end
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      bus.en  = 1'b1;
      bus.a   = 16'h8001;
      bus.sel = 1'b1;
      #1;
      n_tests++;
      if (bus.z_q !== 32'h0 || bus.valid_q !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: got z_q=%h valid=%b, expected 0/0", bus.z_q, bus.valid_q);
      end
      n_tests++;
      if (bus.z !== 32'hFFFF8001) begin
         n_fail++;
         $display("FAIL reset_comb: got z=%h, expected ffff8001", bus.z);
      end
      @(posedge clk);
      #1;
      n_tests++;
      if (bus.valid_q !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_no_capture: got valid=%b, expected 0", bus.valid_q);
      end
      @(negedge clk);
      bus.en = 1'b0;
      rst_n  = 1'b1;
   endtask

   task automatic test_comb();
      logic [15:0] va[8];
      logic        vs[8];
      logic [31:0] vz[8];
      logic [15:0] ra;
      logic        rs;
      va = '{16'h0001, 16'hFFFF, 16'hAAAA, 16'hAAAA, 16'h78D6, 16'h78D6, 16'h8000, 16'h7FFF};
      vs = '{1'b1,     1'b1,     1'b1,     1'b0,     1'b1,     1'b0,     1'b0,     1'b1};
      vz = '{32'h00000001, 32'hFFFFFFFF, 32'hFFFFAAAA, 32'h0000AAAA,
             32'h000078D6, 32'h000078D6, 32'h00008000, 32'h00007FFF};
      for (int i = 0; i < 8; i++) begin
         bus.a   = va[i];
         bus.sel = vs[i];
         #1;
         n_tests++;
         if (bus.z !== vz[i]) begin
            n_fail++;
            $display("FAIL comb_vec%0d: a=%h sel=%b got z=%h expected %h",
                     i, va[i], vs[i], bus.z, vz[i]);
         end
      end
      for (int i = 0; i < 24; i++) begin
         ra      = 16'($urandom);
         rs      = 1'($urandom);
         bus.a   = ra;
         bus.sel = rs;
         #1;
         n_tests++;
         if (bus.z !== model(ra, rs)) begin
            n_fail++;
            $display("FAIL comb_rand%0d: a=%h sel=%b got z=%h expected %h",
                     i, ra, rs, bus.z, model(ra, rs));
         end
      end
   endtask

   task automatic test_capture_hold();
      @(negedge clk);
      bus.a   = 16'h8000;
      bus.sel = 1'b1;
      bus.en  = 1'b1;
      exp_q.push_back({1'b1, 32'hFFFF8000});
      @(posedge clk);
      #1;
      check_reg("capture");
      @(negedge clk);
      bus.en = 1'b0;
      bus.a  = 16'h0001;
      exp_q.push_back({1'b1, 32'hFFFF8000});
      @(posedge clk);
      #1;
      check_reg("hold");
   endtask

   task automatic test_back_to_back();
      logic [31:0] held;
      logic        e;
      held = 32'hFFFF8000;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         bus.a   = 16'($urandom);
         bus.sel = 1'($urandom);
         e       = (i < 12) ? 1'b1 : 1'($urandom);
         bus.en  = e;
         if (e) held = model(bus.a, bus.sel);
         exp_q.push_back({1'b1, held});
         @(posedge clk);
         #1;
         check_reg("back_to_back");
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      bus.a   = 16'h1234;
      bus.sel = 1'b0;
      bus.en  = 1'b1;
      @(posedge clk);
      #3;
      bus.en = 1'b0;
      rst_n  = 1'b0;
      #1;
      n_tests++;
      if (bus.z_q !== 32'h0 || bus.valid_q !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: got z_q=%h valid=%b, expected 0/0", bus.z_q, bus.valid_q);
      end
      bus.a   = 16'h9234;
      bus.sel = 1'b1;
      bus.en  = 1'b1;
      #1;
      n_tests++;
      if (bus.z !== 32'hFFFF9234) begin
         n_fail++;
         $display("FAIL reset_tracking: got z=%h expected ffff9234", bus.z);
      end
      @(posedge clk);
      #1;
      n_tests++;
      if (bus.z_q !== 32'h0 || bus.valid_q !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_wins: got z_q=%h valid=%b, expected 0/0", bus.z_q, bus.valid_q);
      end
      @(negedge clk);
      rst_n   = 1'b1;
      bus.a   = 16'h00F0;
      bus.sel = 1'b1;
      exp_q.push_back({1'b1, 32'h000000F0});
      @(posedge clk);
      #1;
      check_reg("first_after_release");
      @(negedge clk);
      bus.en = 1'b0;
   endtask

   initial begin
      bus.a   = '0;
      bus.sel = 1'b0;
      bus.en  = 1'b0;
      test_reset();
      test_comb();
      test_capture_hold();
      test_back_to_back();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
